ysyx_25010008_arbiter: RTL and testbench

YSYX_25010008_ARBITER -- requirements
Module: ysyx_25010008_arbiter

---
 rtl/ysyx_25010008_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_ysyx_25010008_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25010008_arbiter.sv
// ysyx_25010008_arbiter: shares one AXI-lite slave port between IFU and LSU.
// One transaction in flight at a time; LSU priority or round-robin arbitration.
module ysyx_25010008_arbiter #(
    parameter int PRIO_LSU = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic        resp_err
);

    typedef enum logic [2:0] {
        IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B
    } state_t;

    localparam logic LP_PRIO = (PRIO_LSU != 0);

    state_t r_state;
    state_t w_next;
    logic   r_last_grant;
    logic   r_aw_done;
    logic   r_w_done;
    logic   r_resp_err;

    logic   w_lsu_req;
    logic   w_grant_lsu;
    logic   w_ar_hs;
    logic   w_r_hs;
    logic   w_aw_hs;
    logic   w_w_hs;
    logic   w_b_hs;
    logic   w_wr_done;

    // r_last_grant: 0 = IFU served last, 1 = LSU served last
    assign w_lsu_req   = lsu_arvalid | lsu_awvalid;
    assign w_grant_lsu = w_lsu_req & (~ifu_arvalid | LP_PRIO | ~r_last_grant);

    assign w_ar_hs   = m_arvalid & m_arready;
    assign w_r_hs    = m_rvalid & m_rready;
    assign w_aw_hs   = m_awvalid & m_awready;
    assign w_w_hs    = m_wvalid & m_wready;
    assign w_b_hs    = m_bvalid & m_bready;
    assign w_wr_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    assign resp_err = r_resp_err;

    // Route only the granted master's channels to the slave port
    always_comb begin
        m_araddr    = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awaddr    = '0;
        m_awvalid   = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;
        unique case (r_state)
            IFU_AR: begin
                m_araddr    = ifu_araddr;
                m_arvalid   = ifu_arvalid;
                ifu_arready = m_arready;
            end
            IFU_R: begin
                ifu_rdata  = m_rdata;
                ifu_rresp  = m_rresp;
                ifu_rvalid = m_rvalid;
                m_rready   = ifu_rready;
            end
            LSU_AR: begin
                m_araddr    = lsu_araddr;
                m_arvalid   = lsu_arvalid;
                lsu_arready = m_arready;
            end
            LSU_R: begin
                lsu_rdata  = m_rdata;
                lsu_rresp  = m_rresp;
                lsu_rvalid = m_rvalid;
                m_rready   = lsu_rready;
            end
            LSU_W: begin
                m_awaddr    = lsu_awaddr;
                m_awvalid   = lsu_awvalid & ~r_aw_done;
                lsu_awready = m_awready & ~r_aw_done;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                m_wvalid    = lsu_wvalid & ~r_w_done;
                lsu_wready  = m_wready & ~r_w_done;
            end
            LSU_B: begin
                lsu_bresp  = m_bresp;
                lsu_bvalid = m_bvalid;
                m_bready   = lsu_bready;
            end
            default: begin
            end
        endcase
    end

    // Next-state: arbitrate in IDLE, advance on each channel handshake
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_lsu) begin
                    w_next = lsu_awvalid ? LSU_W : LSU_AR;
                end else if (ifu_arvalid) begin
                    w_next = IFU_AR;
                end
            end
            IFU_AR: if (w_ar_hs) w_next = IFU_R;
            IFU_R:  if (w_r_hs) w_next = IDLE;
            LSU_AR: if (w_ar_hs) w_next = LSU_R;
            LSU_R:  if (w_r_hs) w_next = IDLE;
            LSU_W:  if (w_wr_done) w_next = LSU_B;
            LSU_B:  if (w_b_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // AW/W completion flags; cleared when the write moves to B
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == LSU_W) begin
            if (w_wr_done) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

    // Remember who finished last for round-robin
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b0;
        end else if (r_state == IFU_R && w_r_hs) begin
            r_last_grant <= 1'b0;
        end else if ((r_state == LSU_R && w_r_hs) ||
                     (r_state == LSU_B && w_b_hs)) begin
            r_last_grant <= 1'b1;
        end
    end

    // One-cycle error pulse after a non-OKAY response handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_err <= 1'b0;
        end else begin
            r_resp_err <= (w_r_hs & (|m_rresp)) | (w_b_hs & (|m_bresp));
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_arbiter.sv
// tb_ysyx_25010008_arbiter: both priority modes driven by random masters and
// a random slave, checked against a transaction-level arbitration model.
module tb_ysyx_25010008_arbiter;

    logic        clock;
    logic        reset;
    logic        sel;

    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic        lsu_rready;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wvalid;
    logic        lsu_bready;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_awready;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;

    logic [1:0]        ifu_arready_a, ifu_rvalid_a, lsu_arready_a, lsu_rvalid_a;
    logic [1:0]        lsu_awready_a, lsu_wready_a, lsu_bvalid_a;
    logic [1:0]        m_arvalid_a, m_rready_a, m_awvalid_a, m_wvalid_a;
    logic [1:0]        m_bready_a, resp_err_a;
    logic [1:0][31:0]  ifu_rdata_a, lsu_rdata_a, m_araddr_a, m_awaddr_a, m_wdata_a;
    logic [1:0][1:0]   ifu_rresp_a, lsu_rresp_a, lsu_bresp_a;
    logic [1:0][3:0]   m_wstrb_a;

    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid;
    logic        lsu_awready, lsu_wready, lsu_bvalid;
    logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_err;
    logic [31:0] ifu_rdata, lsu_rdata, m_araddr, m_awaddr, m_wdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
    logic [3:0]  m_wstrb;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_25010008_arbiter #(.PRIO_LSU(g)) u_dut (
            .clock       (clock),
            .reset       (reset),
            .ifu_araddr  (ifu_araddr),
            .ifu_arvalid (ifu_arvalid),
            .ifu_arready (ifu_arready_a[g]),
            .ifu_rdata   (ifu_rdata_a[g]),
            .ifu_rresp   (ifu_rresp_a[g]),
            .ifu_rvalid  (ifu_rvalid_a[g]),
            .ifu_rready  (ifu_rready),
            .lsu_araddr  (lsu_araddr),
            .lsu_arvalid (lsu_arvalid),
            .lsu_arready (lsu_arready_a[g]),
            .lsu_rdata   (lsu_rdata_a[g]),
            .lsu_rresp   (lsu_rresp_a[g]),
            .lsu_rvalid  (lsu_rvalid_a[g]),
            .lsu_rready  (lsu_rready),
            .lsu_awaddr  (lsu_awaddr),
            .lsu_awvalid (lsu_awvalid),
            .lsu_awready (lsu_awready_a[g]),
            .lsu_wdata   (lsu_wdata),
            .lsu_wstrb   (lsu_wstrb),
            .lsu_wvalid  (lsu_wvalid),
            .lsu_wready  (lsu_wready_a[g]),
            .lsu_bresp   (lsu_bresp_a[g]),
            .lsu_bvalid  (lsu_bvalid_a[g]),
            .lsu_bready  (lsu_bready),
            .m_araddr    (m_araddr_a[g]),
            .m_arvalid   (m_arvalid_a[g]),
            .m_arready   (m_arready),
            .m_rdata     (m_rdata),
            .m_rresp     (m_rresp),
            .m_rvalid    (m_rvalid),
            .m_rready    (m_rready_a[g]),
            .m_awaddr    (m_awaddr_a[g]),
            .m_awvalid   (m_awvalid_a[g]),
            .m_awready   (m_awready),
            .m_wdata     (m_wdata_a[g]),
            .m_wstrb     (m_wstrb_a[g]),
            .m_wvalid    (m_wvalid_a[g]),
            .m_wready    (m_wready),
            .m_bresp     (m_bresp),
            .m_bvalid    (m_bvalid),
            .m_bready    (m_bready_a[g]),
            .resp_err    (resp_err_a[g])
        );
    end

    assign ifu_arready = ifu_arready_a[sel];
    assign ifu_rdata   = ifu_rdata_a[sel];
    assign ifu_rresp   = ifu_rresp_a[sel];
    assign ifu_rvalid  = ifu_rvalid_a[sel];
    assign lsu_arready = lsu_arready_a[sel];
    assign lsu_rdata   = lsu_rdata_a[sel];
    assign lsu_rresp   = lsu_rresp_a[sel];
    assign lsu_rvalid  = lsu_rvalid_a[sel];
    assign lsu_awready = lsu_awready_a[sel];
    assign lsu_wready  = lsu_wready_a[sel];
    assign lsu_bresp   = lsu_bresp_a[sel];
    assign lsu_bvalid  = lsu_bvalid_a[sel];
    assign m_araddr    = m_araddr_a[sel];
    assign m_arvalid   = m_arvalid_a[sel];
    assign m_rready    = m_rready_a[sel];
    assign m_awaddr    = m_awaddr_a[sel];
    assign m_awvalid   = m_awvalid_a[sel];
    assign m_wdata     = m_wdata_a[sel];
    assign m_wstrb     = m_wstrb_a[sel];
    assign m_wvalid    = m_wvalid_a[sel];
    assign m_bready    = m_bready_a[sel];
    assign resp_err    = resp_err_a[sel];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total;
    int bad;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] hs_outs();
        return {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
                lsu_awready, lsu_wready, lsu_bvalid};
    endfunction

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0413;
    endfunction

    // bench-side master, slave and arbitration-model state
    bit          i_pend, i_ar_sent;
    logic [31:0] i_addr;
    bit          l_pend, l_wr, l_ar_sent, l_aw_sent, l_w_sent;
    logic [31:0] l_addr, l_data;
    logic [3:0]  l_strb;
    bit          s_rd_pend, s_rv, s_aw, s_w, s_bv;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    bit          busy, owner, last_lsu, exp_err;
    int          ntx, busy_cyc;

    task automatic clear_inputs();
        ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
        lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0;
        lsu_wstrb = '0; lsu_wvalid = 0; lsu_bready = 0;
        m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        i_pend = 0; i_ar_sent = 0; i_addr = '0;
        l_pend = 0; l_wr = 0; l_ar_sent = 0; l_aw_sent = 0; l_w_sent = 0;
        l_addr = '0; l_data = '0; l_strb = '0;
        s_rd_pend = 0; s_rv = 0; s_aw = 0; s_w = 0; s_bv = 0;
        s_rdata = '0; s_rresp = '0; s_bresp = '0;
        busy = 0; owner = 0; last_lsu = 0; exp_err = 0; ntx = 0; busy_cyc = 0;
        repeat (2) @(negedge clock);
        check("rst_hs", 64'(hs_outs()), 64'(0));
        check("rst_err", 64'(resp_err), 64'(0));
        reset = 1'b0;
    endtask

    task automatic drive_cycle();
        if (!i_pend && $urandom_range(0, 2) == 0) begin
            i_pend = 1; i_ar_sent = 0;
            i_addr = 32'($urandom) & 32'hFFFF_FFFC;
        end
        if (!l_pend && $urandom_range(0, 2) == 0) begin
            l_pend = 1; l_wr = 1'($urandom_range(0, 1));
            l_ar_sent = 0; l_aw_sent = 0; l_w_sent = 0;
            l_addr = 32'($urandom) & 32'hFFFF_FFFC;
            l_data = 32'($urandom);
            l_strb = 4'($urandom_range(1, 15));
        end
        ifu_araddr  = i_addr;
        ifu_arvalid = i_pend && !i_ar_sent;
        ifu_rready  = $urandom_range(0, 3) != 0;
        lsu_araddr  = l_addr;
        lsu_awaddr  = l_addr;
        lsu_wdata   = l_data;
        lsu_wstrb   = l_strb;
        lsu_arvalid = l_pend && !l_wr && !l_ar_sent;
        lsu_awvalid = l_pend && l_wr && !(l_aw_sent && l_w_sent);
        lsu_wvalid  = lsu_awvalid;
        lsu_rready  = $urandom_range(0, 3) != 0;
        lsu_bready  = $urandom_range(0, 3) != 0;
        m_arready   = 1'($urandom_range(0, 1));
        m_awready   = 1'($urandom_range(0, 1));
        m_wready    = 1'($urandom_range(0, 1));
        if (s_rd_pend && !s_rv && $urandom_range(0, 2) == 0) s_rv = 1;
        if (s_aw && s_w && !s_bv && $urandom_range(0, 2) == 0) s_bv = 1;
        m_rvalid = s_rv; m_rdata = s_rdata; m_rresp = s_rresp;
        m_bvalid = s_bv; m_bresp = s_bresp;
    endtask

    task automatic observe_cycle();
        check("resp_err", 64'(resp_err), 64'(exp_err));
        exp_err = 0;
        if (!busy) begin
            check("idle_hs", 64'(hs_outs()), 64'(0));
            if (ifu_arvalid || lsu_arvalid || lsu_awvalid) begin
                if (ifu_arvalid && (lsu_arvalid || lsu_awvalid))
                    owner = sel ? 1'b1 : ~last_lsu;
                else
                    owner = lsu_arvalid || lsu_awvalid;
                last_lsu = owner;
                busy = 1;
            end
            busy_cyc = 0;
            return;
        end
        busy_cyc++;
        if (busy_cyc == 200) check("stuck", 64'(busy_cyc), 64'(0));
        if (!owner) begin
            check("lsu_quiet", 64'({lsu_arready, lsu_rvalid, lsu_awready,
                  lsu_wready, lsu_bvalid, m_awvalid, m_wvalid, m_bready}), 64'(0));
            if (!i_ar_sent)
                check("ifu_ar_fwd", 64'({m_arvalid, ifu_arready, m_araddr}),
                      64'({1'b1, m_arready, i_addr}));
        end else begin
            check("ifu_quiet", 64'({ifu_arready, ifu_rvalid}), 64'(0));
            if (!l_wr && !l_ar_sent)
                check("lsu_ar_fwd", 64'({m_arvalid, lsu_arready, m_araddr}),
                      64'({1'b1, m_arready, l_addr}));
            if (l_wr && !(l_aw_sent && l_w_sent)) begin
                check("aw_fwd", 64'({m_awvalid, lsu_awready}),
                      64'(l_aw_sent ? 2'b00 : {1'b1, m_awready}));
                check("w_fwd", 64'({m_wvalid, lsu_wready}),
                      64'(l_w_sent ? 2'b00 : {1'b1, m_wready}));
            end
        end
        if (ifu_arvalid && ifu_arready) i_ar_sent = 1;
        if (lsu_arvalid && lsu_arready) l_ar_sent = 1;
        if (m_arvalid && m_arready) begin
            s_rd_pend = 1;
            s_rdata = rd_of(m_araddr);
            s_rresp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        end
        if (s_rv)
            check("r_fwd", 64'({owner ? lsu_rvalid : ifu_rvalid, m_rready}),
                  64'({1'b1, owner ? lsu_rready : ifu_rready}));
        if (ifu_rvalid && ifu_rready) begin
            check("ifu_rdata", 64'({ifu_rresp, ifu_rdata}), 64'({s_rresp, rd_of(i_addr)}));
            i_pend = 0; busy = 0; ntx++;
        end
        if (lsu_rvalid && lsu_rready) begin
            check("lsu_rdata", 64'({lsu_rresp, lsu_rdata}), 64'({s_rresp, rd_of(l_addr)}));
            l_pend = 0; busy = 0; ntx++;
        end
        if (m_rvalid && m_rready) begin
            exp_err = |s_rresp; s_rv = 0; s_rd_pend = 0;
        end
        if (lsu_awvalid && lsu_awready) l_aw_sent = 1;
        if (lsu_wvalid && lsu_wready) l_w_sent = 1;
        if (m_awvalid && m_awready) begin
            check("awaddr", 64'(m_awaddr), 64'(l_addr));
            s_aw = 1;
            s_bresp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        end
        if (m_wvalid && m_wready) begin
            check("wdata", 64'({m_wstrb, m_wdata}), 64'({l_strb, l_data}));
            s_w = 1;
        end
        if (s_bv)
            check("b_fwd", 64'({lsu_bvalid, m_bready}), 64'({1'b1, lsu_bready}));
        if (lsu_bvalid && lsu_bready) begin
            check("bresp", 64'(lsu_bresp), 64'(s_bresp));
            l_pend = 0; busy = 0; ntx++;
        end
        if (m_bvalid && m_bready) begin
            exp_err = |s_bresp; s_bv = 0; s_aw = 0; s_w = 0;
        end
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock);
            #1;
            drive_cycle();
            @(negedge clock);
            observe_cycle();
        end
        check("progress", 64'(ntx >= 50), 64'(1));
    endtask

    initial begin
        total = 0;
        bad = 0;
        sel = 1'b1;
        reset = 1'b1;
        do_reset();

        // IFU read, slave answers two cycles after the address
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1; ifu_rready = 1; m_arready = 1;
        @(negedge clock);
        check("d_ifu_ar", 64'({m_arvalid, ifu_arready, m_araddr}),
              64'({2'b11, 32'h8000_0000}));
        @(negedge clock);
        ifu_arvalid = 0; m_arready = 0;
        check("d_ifu_wait", 64'({ifu_rvalid, m_rready}), 64'(2'b01));
        @(negedge clock);
        m_rvalid = 1; m_rdata = 32'h0000_0413; m_rresp = 2'b00;
        #1;
        check("d_ifu_r", 64'({ifu_rvalid, ifu_rresp, ifu_rdata}),
              64'({3'b100, 32'h0000_0413}));
        @(negedge clock);
        m_rvalid = 0;
        check("d_ifu_idle", 64'(hs_outs()), 64'(0));
        check("d_ifu_err", 64'(resp_err), 64'(0));

        // write request beats read request from the same LSU
        do_reset();
        lsu_arvalid = 1; lsu_awvalid = 1; lsu_wvalid = 1;
        @(negedge clock);
        check("d_aw_first", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'(3'b110));

        // reset in LSU_R drops handshake outputs without a clock edge
        do_reset();
        lsu_araddr = 32'h2000_0000; lsu_arvalid = 1; m_arready = 1;
        repeat (2) @(negedge clock);
        lsu_arvalid = 0; m_arready = 0;
        m_rvalid = 1; m_rdata = 32'h1234_5678; lsu_rready = 1;
        ifu_araddr = 32'h8000_0010; ifu_arvalid = 1;
        #1;
        check("d_lsu_r", 64'({lsu_rvalid, m_rready, lsu_rdata}),
              64'({2'b11, 32'h1234_5678}));
        reset = 1'b1;
        #1;
        check("d_rst_async", 64'({lsu_rvalid, m_rready}), 64'(0));
        m_rvalid = 0; lsu_rready = 0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("d_rst_regrant", 64'({m_arvalid, ifu_arready, m_araddr}),
              64'({2'b10, 32'h8000_0010}));

        sel = 1'b0;
        do_reset();
        run_random(3000);
        sel = 1'b1;
        do_reset();
        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
